// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the sram-like data interface.
// Word-addressed memory. Requests are accepted in order on the address channel.
// Each request is answered with a single data_ok pulse exactly RESP_DELAY cycles
// after its address handshake.
//
// Handshake: a request is taken in any cycle where data_sram_req && data_sram_addr_ok.
// addr_ok depends only on the registered queue count. data_ok is a registered
// one-cycle pulse that is never held, because the requester cannot stall it.
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int OUTSTANDING = 4,
  parameter int RESP_DELAY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  // A timer holds the cycles left until the cycle whose edge raises data_ok.
  localparam int TW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

  logic [31:0]   mem [2**ADDR_W];
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          q_wr    [OUTSTANDING];
  logic [31:0]   q_data  [OUTSTANDING];
  logic [TW-1:0] q_timer [OUTSTANDING];

  logic [ADDR_W-1:0] idx;
  logic              push;
  logic              pop;
  logic              resp_hit;
  logic              resp_wr;
  logic [31:0]       resp_data;

  // Size, the alias bits and the byte offset do not affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign data_sram_addr_ok = !reset && (count < CW'(OUTSTANDING));
  assign push              = data_sram_req && data_sram_addr_ok;
  // The entry answering this cycle is always the head; it leaves at this cycle's edge.
  assign pop               = data_sram_data_ok;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Choose the entry whose pulse must be raised at the coming edge.
  // Timers are unique because at most one request is accepted per cycle.
  always_comb begin
    resp_hit  = 1'b0;
    resp_wr   = 1'b0;
    resp_data = '0;
    if (RESP_DELAY == 1) begin
      resp_hit  = push;
      resp_wr   = data_sram_wr;
      resp_data = mem[idx];
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (q_timer[i] == TW'(1)) begin
          resp_hit  = 1'b1;
          resp_wr   = q_wr[i];
          resp_data = q_data[i];
        end
      end
    end
  end

  // Queue bookkeeping and the registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count             <= '0;
      head              <= '0;
      tail              <= '0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        q_wr[i]    <= 1'b0;
        q_data[i]  <= '0;
        q_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (q_timer[i] != '0) q_timer[i] <= q_timer[i] - TW'(1);
      end
      if (pop) head <= ptr_next(head);
      if (push) begin
        q_wr[tail]    <= data_sram_wr;
        q_data[tail]  <= data_sram_wr ? 32'h0 : mem[idx];
        q_timer[tail] <= TW'(RESP_DELAY - 1);
        tail          <= ptr_next(tail);
      end
      count             <= count + CW'(push) - CW'(pop);
      data_sram_data_ok <= resp_hit;
      data_sram_rdata   <= (resp_hit && !resp_wr) ? resp_data : 32'h0;
    end
  end

  // Byte-masked writes. The array has no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder. Three instances with different delays and depths
// share the data-side inputs and have separate req lines. The scoreboard queue
// holds {dut id, due cycle, rdata} for each accepted request.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  aok;
  logic [2:0]  dok;
  logic [31:0] rd0, rd1, rd2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [2:0] acc;
  logic [63:0] exp_q[$];
  logic [31:0] model_mem [3][1024];

  // Clock and reset
  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .OUTSTANDING(4), .RESP_DELAY(2)) u_main (
    .clk(clk), .reset(reset), .data_sram_req(req[0]), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
    .data_sram_rdata(rd0));

  data_sram_responder #(.ADDR_W(10), .OUTSTANDING(4), .RESP_DELAY(8)) u_slow (
    .clk(clk), .reset(reset), .data_sram_req(req[1]), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
    .data_sram_rdata(rd1));

  data_sram_responder #(.ADDR_W(10), .OUTSTANDING(4), .RESP_DELAY(1)) u_fast (
    .clk(clk), .reset(reset), .data_sram_req(req[2]), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]),
    .data_sram_rdata(rd2));

  function automatic int dly(input int d);
    case (d)
      0:       return 2;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Scoreboard step for one instance at the negedge of the current cycle.
  task automatic check_dut(input int d);
    logic a, o;
    logic [31:0] r, edata;
    int n, first, due;
    logic [9:0] idx;
    a = aok[d];
    o = dok[d];
    r = (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
    n = 0;
    first = -1;
    foreach (exp_q[i]) begin
      if (int'(exp_q[i][63:62]) == d) begin
        if (first < 0) first = i;
        n++;
      end
    end
    checks++;
    assert (a === (!reset && n < 4)) else begin
      errors++;
      $error("FAIL addr_ok dut%0d cyc%0d: got %b want %b", d, cyc, a, (!reset && n < 4));
    end
    if (reset) begin
      checks++;
      assert (o === 1'b0 && r === 32'h0) else begin
        errors++;
        $error("FAIL reset_out dut%0d cyc%0d: got ok=%b rdata=%h want ok=0 rdata=0", d, cyc, o, r);
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (int'(exp_q[i][63:62]) == d) exp_q.delete(i);
      end
    end else if (o) begin
      due = (first >= 0) ? int'(exp_q[first][61:32]) : -1;
      edata = (first >= 0) ? exp_q[first][31:0] : 32'h0;
      checks++;
      assert (first >= 0 && due == cyc && r === edata) else begin
        errors++;
        $error("FAIL resp dut%0d cyc%0d: got ok=1 rdata=%h want due=%0d rdata=%h", d, cyc, r, due, edata);
      end
      if (first >= 0) exp_q.delete(first);
    end else if (first >= 0) begin
      due = int'(exp_q[first][61:32]);
      checks++;
      assert (due > cyc) else begin
        errors++;
        $error("FAIL missing_resp dut%0d cyc%0d: got ok=0 want ok=1 (due %0d)", d, cyc, due);
      end
    end
    if (!reset && req[d] && a) begin
      acc[d] = 1'b1;
      idx = addr[11:2];
      edata = wr ? 32'h0 : model_mem[d][idx];
      exp_q.push_back({2'(d), 30'(cyc + dly(d)), edata});
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) model_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  endtask

  task automatic tick();
    acc = '0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Driver: present one request to the masked instances until each has taken it.
  task automatic issue(input logic [2:0] mask, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] dat);
    logic [2:0] pend;
    wr = w;
    addr = a;
    wstrb = s;
    wdata = dat;
    pend = mask;
    for (int k = 0; k < 64 && pend != 3'b000; k++) begin
      req = pend;
      tick();
      pend = pend & ~acc;
    end
    req = '0;
    checks++;
    assert (pend == 3'b000) else begin
      errors++;
      $error("FAIL accept_timeout addr=%h: got pending=%b want 000", a, pend);
    end
  endtask

  initial begin
    int nacc;
    logic exp_acc;
    reset = 1'b1;
    req = '0;
    wr = 1'b0;
    size = 2'd2;
    wstrb = 4'h0;
    addr = '0;
    wdata = '0;
    #1;
    idle(3);
    reset = 1'b0;
    idle(1);

    // Known contents for the slow and fast instances.
    for (int k = 0; k < 20; k++) begin
      issue((k < 8) ? 3'b110 : 3'b100, 1'b1, 32'(k * 4), 4'hF, $urandom);
    end
    idle(12);

    // Write then read-after-write on consecutive cycles.
    issue(3'b001, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(3'b001, 1'b0, 32'h10, 4'(($urandom_range(0, 15))), $urandom);
    idle(4);

    // Partial byte write merges into the existing word.
    issue(3'b001, 1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(3'b001, 1'b1, 32'h20, 4'b0010, 32'h0000AA00);
    issue(3'b001, 1'b0, 32'h20, 4'h0, 32'h0);
    idle(4);

    // Aliasing and zero-strobe write.
    issue(3'b001, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
    issue(3'b001, 1'b0, 32'h0000, 4'h0, 32'h0);
    issue(3'b001, 1'b1, 32'h0000, 4'h0, 32'hFFFFFFFF);
    issue(3'b001, 1'b0, 32'h7003, 4'h0, 32'h0);
    idle(4);

    // Full queue throttling with delay 8, depth 4.
    nacc = 0;
    wr = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      req = 3'b010;
      addr = 32'((nacc % 8) * 4);
      tick();
      exp_acc = (k <= 3) || (k >= 9);
      checks++;
      assert (acc[1] === exp_acc) else begin
        errors++;
        $error("FAIL throttle k=%0d: got accept=%b want %b", k, acc[1], exp_acc);
      end
      if (acc[1]) nacc++;
    end
    req = '0;
    idle(12);

    // Back-to-back reads with delay 1.
    for (int k = 0; k < 20; k++) begin
      req = 3'b100;
      wr = 1'b0;
      addr = 32'(k * 4);
      tick();
      checks++;
      assert (acc[2] === 1'b1) else begin
        errors++;
        $error("FAIL stream k=%0d: got accept=%b want 1", k, acc[2]);
      end
    end
    req = '0;
    idle(4);

    // Reset with three reads pending on the slow instance.
    issue(3'b010, 1'b0, 32'h0, 4'h0, 32'h0);
    issue(3'b010, 1'b0, 32'h4, 4'h0, 32'h0);
    issue(3'b010, 1'b0, 32'h8, 4'h0, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(12);
    issue(3'b001, 1'b0, 32'h10, 4'h0, 32'h0);
    issue(3'b010, 1'b0, 32'h4, 4'h0, 32'h0);
    idle(12);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d outstanding want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
